plaintext_word_packer: RTL
==========================

Name: plaintext_word_packer

Overview:
- Sits directly downstream of the decryption stage and consumes its byte stream (dout/v).
- Buffers decrypted bytes in a small FIFO and packs them little-endian into N*W_BYTES-bit words.
- Presents each word on a ready/valid output with a byte-keep mask and a last flag.
- The decryption stage has no backpressure, so this block absorbs output stalls and flags any byte it has to drop.

Parameters:
N, 8, byte width (matches the decryption stage data width)
DEPTH, 8, byte FIFO depth; power of two, at least 2
W_BYTES, 4, bytes per output word
EOL, 8'h0A, end-of-line byte that terminates a word early

Ports:
clock  input  1  single clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
din  input  N  decrypted byte from the decryption stage
v  input  1  din valid; one byte per cycle when high
flush  input  1  one-cycle pulse: emit any partially packed word
dout  output  N*W_BYTES  packed word; byte i is dout[N*i+N-1:N*i]
dout_keep  output  W_BYTES  per-byte valid mask, contiguous from bit 0
dout_last  output  1  word ended by EOL or by flush
dout_valid  output  1  word available
dout_ready  input  1  consumer accepts the word
overflow  output  1  sticky: a byte was dropped because the FIFO was full
clr_ovf  input  1  clears overflow
level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
Interface and reset
- One clock; reset is synchronous and active-high.
- Ports are named clock and rst.
- When rst=1 at a rising edge: FIFO emptied, packer cleared, FSM to COLLECT, flush_pend cleared.
- All outputs reset to 0: dout, dout_keep, dout_last, dout_valid, overflow, level.
- A reset asserted mid-word discards both the word and the FIFO contents.

FIFO
- Registered write, with read/write pointers one bit wider than log2(DEPTH).
- When v=1 and the FIFO is not full: din is written; level increments unless a pop happens in the same cycle.
- When v=1, the FIFO is full and there is no pop in that cycle: the byte is dropped and overflow is set.
- When v=1, the FIFO is full and a pop happens in the same cycle: the write is accepted and level is unchanged.
- Priority on overflow: if a drop and clr_ovf occur in the same cycle, overflow is 1 (set wins).

FSM states: COLLECT, EMIT

COLLECT
- If the FIFO is not empty, pop one byte per cycle into lane cnt (cnt is 0..W_BYTES-1), set keep[cnt], and increment cnt.
- Go to EMIT at the end of that cycle when either:
  - the popped byte is the W_BYTES-th byte (last=0), or
  - the popped byte equals EOL; the EOL byte is included in the word and last=1.
- If the popped byte both fills the word and equals EOL, last=1.
- If flush_pend=1, the FIFO is empty and cnt>0: go to EMIT with last=1.
- If flush_pend=1, the FIFO is empty and cnt=0: clear flush_pend; no word is produced.

EMIT
- dout_valid=1. dout, dout_keep and dout_last are held stable; unused lanes of dout are 0.
- No pops occur in EMIT. The FIFO continues to accept input.
- When dout_ready=1: the handshake completes, dout_valid drops next cycle, and the packer clears (cnt=0, keep=0).
- If dout_last=1 at the handshake, flush_pend is cleared. Return to COLLECT.

flush
- A flush pulse sets flush_pend.
- Bytes that arrive before the FIFO drains are included in the flushed word(s).
- A flush pulse arriving in the same cycle as the handshake that clears flush_pend re-arms it (set wins).

Latency
- With the FIFO and packer empty, a word-completing byte presented in cycle t gives dout_valid=1 in cycle t+2.
- Sustained throughput is one word per W_BYTES+1 cycles when dout_ready=1.

Test Plan:
- Reset; then v=1 with din 41,42,43,44 on consecutive cycles, dout_ready=1 -> dout=32'h44434241, keep=4'hF, last=0, dout_valid high 2 cycles after byte 44; all outputs 0 during reset.
- Bytes 68,69,0A -> dout=32'h000A6968, keep=4'h7, last=1.
- Bytes 61,62, then a flush pulse -> dout=32'h00006261, keep=4'h3, last=1; a second flush with nothing buffered -> no word produced.
- dout_ready=0; stream 16 bytes (DEPTH=8) -> the first word is held stable in EMIT, the FIFO fills, level=8, later bytes are dropped and overflow=1; release ready -> exactly 3 words (12 bytes) emitted in order; clr_ovf -> overflow=0.
- FIFO full with the packer in COLLECT popping and v=1 in the same cycle -> write accepted, level stays 8, overflow stays 0; a drop coinciding with clr_ovf -> overflow=1.
- Assert rst while in EMIT with 5 bytes in the FIFO -> next cycle dout_valid=0, level=0, keep=0; subsequent bytes 41..44 pack normally.

Source files
------------

// File: rtl/plaintext_word_packer.sv
// Byte FIFO plus little-endian word packer behind the decryption stage.
// Words leave on a ready/valid port with a keep mask and a last flag.
module plaintext_word_packer #(
    parameter int            N       = 8,
    parameter int            DEPTH   = 8,
    parameter int            W_BYTES = 4,
    parameter logic [N-1:0]  EOL     = 8'h0A
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [N-1:0]             din,
    input  logic                     v,
    input  logic                     flush,
    output logic [N*W_BYTES-1:0]     dout,
    output logic [W_BYTES-1:0]       dout_keep,
    output logic                     dout_last,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (W_BYTES > 1) ? $clog2(W_BYTES) : 1;

    typedef enum logic {COLLECT, EMIT} state_t;

    // Handshake: a word transfers on a rising edge where dout_valid and
    // dout_ready are both high; dout/keep/last stay stable until then.

    logic [N-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] cnt;
    logic          flush_pend;
    state_t        state;

    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic          handshake;
    logic [N-1:0]  pop_byte;
    logic          flush_emit;
    logic          flush_done;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = (state == COLLECT) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = v && (!full || pop);
    assign drop      = v && full && !pop;
    assign handshake = (state == EMIT) && dout_ready;
    assign pop_byte  = mem[rd_ptr[AW-1:0]];

    assign flush_emit = (state == COLLECT) && empty && flush_pend && (dout_keep != '0);
    assign flush_done = ((state == COLLECT) && empty && flush_pend && (dout_keep == '0)) ||
                        (handshake && dout_last);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            flush_pend <= 1'b0;
            state      <= COLLECT;
            cnt        <= '0;
            dout       <= '0;
            dout_keep  <= '0;
            dout_last  <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            // A new flush pulse re-arms even when the old one retires now.
            if (flush) begin
                flush_pend <= 1'b1;
            end else if (flush_done) begin
                flush_pend <= 1'b0;
            end

            case (state)
                COLLECT: begin
                    if (pop) begin
                        dout[cnt*N +: N] <= pop_byte;
                        dout_keep[cnt]   <= 1'b1;
                        cnt              <= cnt + CW'(1);
                        if ((cnt == CW'(W_BYTES - 1)) || (pop_byte == EOL)) begin
                            state      <= EMIT;
                            dout_valid <= 1'b1;
                            dout_last  <= (pop_byte == EOL);
                        end
                    end else if (flush_emit) begin
                        state      <= EMIT;
                        dout_valid <= 1'b1;
                        dout_last  <= 1'b1;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        state      <= COLLECT;
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        dout       <= '0;
                        dout_keep  <= '0;
                        cnt        <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
